// File: rtl/pc_fetch.sv
// pc_fetch: PC register and req/ack instruction fetch with next-PC select.
// Optional PC_FETCH_ALIGN_TRAP_EN traps misaligned targets into FAULT.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Imem_addr,
  output logic        Imem_req,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_data,
  output logic [31:0] Inst,
  output logic        Inst_valid,
  output logic [15:0] Imm16,
  input  logic [31:0] Ext_imm,
  input  logic [1:0]  Pcsrc,
  input  logic [31:0] Rs_data,
  input  logic        Advance,
  output logic [31:0] Pc,
  output logic [31:0] Inst_count,
  output logic        Misalign
);
`ifdef PC_FETCH_ALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;
  logic mis_q, mis_d;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d, pc4, npc_raw, npc;
  always_comb begin
    pc4 = pc_q + 32'd4;
    npc_raw = Pcsrc == 2'b00 ? pc4 :
              Pcsrc == 2'b01 ? pc4 + (Ext_imm << 2) :
              Pcsrc == 2'b10 ? {pc4[31:28], inst_q[25:0], 2'b00} : Rs_data;
`ifdef PC_FETCH_ALIGN_TRAP_EN
    npc = npc_raw;
    mis_d = mis_q;
`else
    npc = {npc_raw[31:2], 2'b00};
`endif
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (Imem_ack) begin
        inst_d = Imem_data;
        state_d = HOLD;
      end
      HOLD: if (Advance) begin
        pc_d = npc;
        cnt_d = cnt_q + 32'd1;
        state_d = FETCH;
`ifdef PC_FETCH_ALIGN_TRAP_EN
        if (npc[1:0] != 2'b00) begin
          mis_d = 1'b1;
          state_d = FAULT;
        end
`endif
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      inst_q <= '0;
      cnt_q <= '0;
`ifdef PC_FETCH_ALIGN_TRAP_EN
      mis_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      cnt_q <= cnt_d;
`ifdef PC_FETCH_ALIGN_TRAP_EN
      mis_q <= mis_d;
`endif
    end
  end
  assign Pc = pc_q;
  assign Imem_addr = pc_q;
  assign Imem_req = state_q == FETCH;
  assign Inst_valid = state_q == HOLD;
  assign Inst = inst_q;
  assign Imm16 = inst_q[15:0];
  assign Inst_count = cnt_q;
`ifdef PC_FETCH_ALIGN_TRAP_EN
  assign Misalign = mis_q;
`else
  assign Misalign = 1'b0;
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven fetch/next-PC vectors plus handshake, reset and alignment sequences.
module tb_pc_fetch;
  logic Clk = 0, Reset = 1, Imem_req, Imem_ack = 0, Inst_valid, Advance = 0, Misalign;
  logic [31:0] Imem_addr, Imem_data = 0, Inst, Ext_imm = 0, Rs_data = 0, Pc, Inst_count;
  logic [15:0] Imm16;
  logic [1:0] Pcsrc = 0;
  int vec_cnt = 0, err_cnt = 0, mcnt = 0;
  logic [31:0] mpc;
  typedef struct {
    logic [31:0] data;
    int dly;
    logic [1:0] src;
    logic [31:0] ext, rs, exp_pc;
  } vec_t;
  vec_t tbl[8];
  always #5 Clk = ~Clk;
  pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .Clk(Clk), .Reset(Reset), .Imem_addr(Imem_addr), .Imem_req(Imem_req),
    .Imem_ack(Imem_ack), .Imem_data(Imem_data), .Inst(Inst), .Inst_valid(Inst_valid),
    .Imm16(Imm16), .Ext_imm(Ext_imm), .Pcsrc(Pcsrc), .Rs_data(Rs_data),
    .Advance(Advance), .Pc(Pc), .Inst_count(Inst_count), .Misalign(Misalign)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    int n = 0;
    while (!Imem_req && n < 10) begin
      tick;
      n++;
    end
    chk("req_wait", Imem_req, 1);
    chk("fetch_addr", Imem_addr, mpc);
    repeat (v.dly) begin
      tick;
      chk("wait_addr", Imem_addr, mpc);
      chk("wait_valid", Inst_valid, 0);
    end
    Imem_ack = 1;
    Imem_data = v.data;
    tick;
    Imem_ack = 0;
    chk("inst_valid", Inst_valid, 1);
    chk("inst", Inst, v.data);
    chk("imm16", Imm16, v.data[15:0]);
    Advance = 1;
    Pcsrc = v.src;
    Ext_imm = v.ext;
    Rs_data = v.rs;
    tick;
    Advance = 0;
    mcnt++;
    chk("next_pc", Pc, v.exp_pc);
    chk("count", Inst_count, mcnt);
    chk("refetch_req", Imem_req, 1);
    mpc = v.exp_pc;
  endtask
  initial begin
    tbl[0] = '{32'h0000_0001, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0004};
    tbl[1] = '{32'h0000_0002, 0, 2'b00, 32'h0, 32'h0, 32'h0000_0008};
    tbl[2] = '{32'h0000_0003, 0, 2'b00, 32'h0, 32'h0, 32'h0000_000C};
    tbl[3] = '{32'h1234_5678, 1, 2'b00, 32'h0, 32'h0, 32'h0000_0010};
    tbl[4] = '{32'h1000_FFFE, 0, 2'b01, 32'hFFFF_FFFE, 32'h0, 32'h0000_000C};
    tbl[5] = '{32'hCAFE_0000, 2, 2'b11, 32'h0, 32'h4000_0000, 32'h4000_0000};
    tbl[6] = '{32'h0800_0040, 0, 2'b10, 32'h0, 32'h0, 32'h4000_0100};
    tbl[7] = '{32'h0000_0000, 0, 2'b11, 32'h0, 32'h0000_2000, 32'h0000_2000};
    // Reset with ack already high: the ack must be dropped until FETCH.
    Imem_ack = 1;
    Imem_data = 32'h1111_2222;
    tick;
    tick;
    chk("rst_req", Imem_req, 0);
    chk("rst_pc", Pc, 32'h0000_3000);
    chk("rst_cnt", Inst_count, 0);
    chk("rst_inst", Inst, 0);
    chk("rst_valid", Inst_valid, 0);
    chk("rst_mis", Misalign, 0);
    Reset = 0;
    chk("idle_req", Imem_req, 0);
    tick;
    chk("first_req", Imem_req, 1);
    chk("first_addr", Imem_addr, 32'h0000_3000);
    chk("first_valid", Inst_valid, 0);
    tick;
    Imem_ack = 0;
    chk("first_hold", Inst_valid, 1);
    chk("first_inst", Inst, 32'h1111_2222);
    Advance = 1;
    Pcsrc = 2'b11;
    Rs_data = 0;
    tick;
    Advance = 0;
    mcnt = 1;
    chk("to_zero_pc", Pc, 0);
    chk("to_zero_cnt", Inst_count, 1);
    mpc = 0;
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    // Advance during FETCH is ignored; address held while ack is late.
    Advance = 1;
    repeat (3) begin
      tick;
      chk("hs_addr", Imem_addr, 32'h0000_2000);
      chk("hs_req", Imem_req, 1);
      chk("hs_valid", Inst_valid, 0);
      chk("hs_cnt", Inst_count, mcnt);
    end
    Advance = 0;
    Imem_ack = 1;
    Imem_data = 32'hAAAA_0001;
    tick;
    Imem_data = 32'hDEAD_BEEF;
    tick;
    Imem_ack = 0;
    chk("spur_inst", Inst, 32'hAAAA_0001);
    chk("spur_valid", Inst_valid, 1);
    chk("spur_pc", Pc, 32'h0000_2000);
    Advance = 1;
    Pcsrc = 2'b00;
    tick;
    Advance = 0;
    chk("hs_next_pc", Pc, 32'h0000_2004);
    chk("hs_next_cnt", Inst_count, mcnt + 1);
    tick;
    Reset = 1;
    Advance = 1;
    tick;
    Reset = 0;
    Advance = 0;
    chk("midrst_pc", Pc, 32'h0000_3000);
    chk("midrst_cnt", Inst_count, 0);
    chk("midrst_req", Imem_req, 0);
    chk("midrst_inst", Inst, 0);
    Imem_ack = 1;
    Imem_data = 32'h5555_5555;
    tick;
    Imem_ack = 0;
    chk("late_req", Imem_req, 1);
    chk("late_valid", Inst_valid, 0);
    chk("late_inst", Inst, 0);
    chk("late_addr", Imem_addr, 32'h0000_3000);
    Imem_ack = 1;
    Imem_data = 32'h0000_0000;
    tick;
    Imem_ack = 0;
    chk("al_hold", Inst_valid, 1);
    Advance = 1;
    Pcsrc = 2'b11;
    Rs_data = 32'h0000_2002;
    tick;
    Advance = 0;
    chk("al_cnt", Inst_count, 1);
`ifdef PC_FETCH_ALIGN_TRAP_EN
    chk("al_pc", Pc, 32'h0000_2002);
    chk("al_mis", Misalign, 1);
    chk("al_req", Imem_req, 0);
    chk("al_valid", Inst_valid, 0);
    Advance = 1;
    Imem_ack = 1;
    repeat (3) begin
      tick;
      chk("fault_req", Imem_req, 0);
      chk("fault_pc", Pc, 32'h0000_2002);
    end
    Advance = 0;
    Imem_ack = 0;
    Reset = 1;
    tick;
    Reset = 0;
    chk("fault_rst_mis", Misalign, 0);
    chk("fault_rst_pc", Pc, 32'h0000_3000);
`else
    chk("al_pc", Pc, 32'h0000_2000);
    chk("al_mis", Misalign, 0);
    chk("al_req", Imem_req, 1);
    Imem_ack = 1;
    Imem_data = 32'h0000_0077;
    tick;
    Imem_ack = 0;
    chk("al_fetch_valid", Inst_valid, 1);
    chk("al_fetch_inst", Inst, 32'h0000_0077);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
